// File: rtl/nios_project_timer_sequencer.sv
// Programs an Avalon-style interval timer, services its timeout irq, and snapshots its counter.
// Bus outputs decode from state only; one access per cycle, reads return data one cycle later.
module nios_project_timer_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [31:0]        period,
  input  logic               continuous,
  input  logic               stop,
  input  logic               snap_req,
  output logic               busy,
  output logic               running,
  output logic               tick,
  output logic               err,
  output logic [COUNT_W-1:0] tick_count,
  output logic               snap_valid,
  output logic [31:0]        snap_value,
  output logic [2:0]         tmr_address,
  output logic               tmr_chipselect,
  output logic               tmr_write_n,
  output logic [15:0]        tmr_writedata,
  input  logic [15:0]        tmr_readdata,
  input  logic               tmr_irq
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_STS, WR_STOP,
    SNAP_WR, SNAP_RDL, SNAP_RDH, SNAP_CAP
  } state_t;

  state_t             state, state_nx;
  logic [31:0]        per_m1;
  logic               cont;
  logic               stop_pend;
  logic               stop_clr;
  logic               err_q;
  logic [15:0]        snap_lo;
  logic [31:0]        snap_reg;
  logic [COUNT_W-1:0] cnt;
  logic               accept;
  logic               stop_eff;
  logic               in_snap;

  assign accept   = (state == IDLE) && start && (period >= 32'd2);
  assign stop_eff = stop || stop_pend;
  assign in_snap  = (state == SNAP_WR) || (state == SNAP_RDL) ||
                    (state == SNAP_RDH) || (state == SNAP_CAP);

  always_comb begin
    state_nx       = state;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'h0000;
    case (state)
      IDLE:     if (accept) state_nx = WR_PL;
      WR_PL: begin
        state_nx = WR_PH;
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 3'd2; tmr_writedata = per_m1[15:0];
      end
      WR_PH: begin
        state_nx = WR_CTRL;
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 3'd3; tmr_writedata = per_m1[31:16];
      end
      WR_CTRL: begin
        state_nx = RUN;
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 3'd1; tmr_writedata = {12'h000, 1'b0, 1'b1, cont, 1'b1};
      end
      // stop outranks irq, irq outranks snapshot
      RUN: begin
        if (stop_eff)      state_nx = WR_STOP;
        else if (tmr_irq)  state_nx = CLR_STS;
        else if (snap_req) state_nx = SNAP_WR;
      end
      CLR_STS: begin
        state_nx = (cont && !stop_clr) ? RUN : IDLE;
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 3'd0;
      end
      WR_STOP: begin
        state_nx = CLR_STS;
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 3'd1; tmr_writedata = 16'h0008;
      end
      SNAP_WR: begin
        state_nx = SNAP_RDL;
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 3'd4;
      end
      SNAP_RDL: begin
        state_nx = SNAP_RDH;
        tmr_chipselect = 1'b1; tmr_address = 3'd4;
      end
      SNAP_RDH: begin
        state_nx = SNAP_CAP;
        tmr_chipselect = 1'b1; tmr_address = 3'd5;
      end
      SNAP_CAP: state_nx = RUN;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      per_m1    <= 32'h0;
      cont      <= 1'b0;
      stop_pend <= 1'b0;
      stop_clr  <= 1'b0;
      err_q     <= 1'b0;
      snap_lo   <= 16'h0;
      snap_reg  <= 32'h0;
      cnt       <= '0;
    end else begin
      state <= state_nx;
      err_q <= (state == IDLE) && start && (period < 32'd2);
      if (accept) begin
        per_m1   <= period - 32'd1;
        cont     <= continuous;
        cnt      <= '0;
        stop_clr <= 1'b0;
      end
      if (state == RUN) begin
        if (stop_eff) begin
          stop_clr  <= 1'b1;
          stop_pend <= 1'b0;
        end else if (tmr_irq) begin
          cnt <= cnt + 1'b1;
        end
      end
      if (in_snap && stop) stop_pend <= 1'b1;
      if (state == SNAP_RDH) snap_lo  <= tmr_readdata;
      if (state == SNAP_CAP) snap_reg <= {tmr_readdata, snap_lo};
    end
  end

  // snapshot is presented on the same cycle as snap_valid, then held in snap_reg
  assign busy       = (state != IDLE);
  assign running    = (state == RUN) || (state == CLR_STS) || in_snap;
  assign tick       = (state == CLR_STS) && !stop_clr;
  assign err        = err_q;
  assign tick_count = cnt;
  assign snap_valid = (state == SNAP_CAP);
  assign snap_value = snap_valid ? {tmr_readdata, snap_lo} : snap_reg;

endmodule

// File: tb/tb_nios_project_timer_sequencer.sv
// Bench for nios_project_timer_sequencer: vector table of start configurations plus hand-written corner sequences.
module tb_nios_project_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] period = 32'h0;
  logic        continuous = 1'b0;
  logic        stop = 1'b0;
  logic        snap_req = 1'b0;
  logic        busy, running, tick, err, snap_valid;
  logic [15:0] tick_count;
  logic [31:0] snap_value;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata = 16'h0;
  logic        tmr_irq = 1'b0;

  nios_project_timer_sequencer #(.COUNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .period(period),
    .continuous(continuous), .stop(stop), .snap_req(snap_req),
    .busy(busy), .running(running), .tick(tick), .err(err),
    .tick_count(tick_count), .snap_valid(snap_valid), .snap_value(snap_value),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] addr; logic [15:0] data; } wr_t;
  typedef struct {
    logic [31:0] per;
    logic        cont;
    logic        rej;
    logic [15:0] pl, ph, ctrl;
  } vec_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  ticks_seen = 0;
  int  exp_ticks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // timer register file model: read data appears one cycle after the address
  always @(posedge clk) begin
    if (tmr_chipselect && tmr_write_n)
      tmr_readdata <= (tmr_address == 3'd4) ? 16'h1234 :
                      (tmr_address == 3'd5) ? 16'h0001 : 16'h0000;
    else
      tmr_readdata <= 16'h0000;
  end

  // bus write scoreboard
  always @(negedge clk) begin
    if (tick === 1'b1) ticks_seen++;
    if (tmr_chipselect === 1'b1 && tmr_write_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", tmr_address, tmr_writedata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("bus_addr", 32'(tmr_address), 32'(w.addr));
        chk("bus_data", 32'(tmr_writedata), 32'(w.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic do_start(input logic [31:0] p, input logic c);
    logic [31:0] pm;
    pm = p - 32'd1;
    start = 1'b1; period = p; continuous = c;
    push(3'd2, pm[15:0]);
    push(3'd3, pm[31:16]);
    push(3'd1, {12'h000, 1'b0, 1'b1, c, 1'b1});
    step();
    start = 1'b0;
    step(); step(); step();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    push(3'd1, 16'h0008);
    push(3'd0, 16'h0000);
    step();
    stop = 1'b0;
    step();
    chk("stop_no_tick", 32'(tick), 32'd0);
    step();
    chk("stop_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    logic [2:0] seq_addr[3];
    int n;
    logic found;
    seq_addr[0] = 3'd2; seq_addr[1] = 3'd3; seq_addr[2] = 3'd1;
    vt[0] = '{per: 32'd50000,      cont: 1'b1, rej: 1'b0, pl: 16'hC34F, ph: 16'h0000, ctrl: 16'h0007};
    vt[1] = '{per: 32'd2,          cont: 1'b0, rej: 1'b0, pl: 16'h0001, ph: 16'h0000, ctrl: 16'h0005};
    vt[2] = '{per: 32'h0001_0000,  cont: 1'b1, rej: 1'b0, pl: 16'hFFFF, ph: 16'h0000, ctrl: 16'h0007};
    vt[3] = '{per: 32'h1234_5679,  cont: 1'b0, rej: 1'b0, pl: 16'h5678, ph: 16'h1234, ctrl: 16'h0005};
    vt[4] = '{per: 32'd1,          cont: 1'b1, rej: 1'b1, pl: 16'h0000, ph: 16'h0000, ctrl: 16'h0000};
    vt[5] = '{per: 32'd0,          cont: 1'b0, rej: 1'b1, pl: 16'h0000, ph: 16'h0000, ctrl: 16'h0000};

    step(); step();
    chk("reset_bus", {tmr_chipselect, tmr_write_n, 11'h0, tmr_address, tmr_writedata}, {1'b0, 1'b1, 30'h0});
    chk("reset_flags", {27'h0, busy, running, tick, err, snap_valid}, 32'h0);
    chk("reset_count", 32'(tick_count), 32'h0);
    reset_n = 1'b1;
    step();

    foreach (vt[i]) begin
      start = 1'b1; period = vt[i].per; continuous = vt[i].cont;
      if (!vt[i].rej) begin
        push(3'd2, vt[i].pl); push(3'd3, vt[i].ph); push(3'd1, vt[i].ctrl);
      end
      step();
      start = 1'b0;
      if (vt[i].rej) begin
        chk("err_pulse", 32'(err), 32'd1);
        step();
        chk("err_single", 32'(err), 32'd0);
        chk("rej_idle", 32'(busy), 32'd0);
      end else begin
        for (int k = 0; k < 3; k++) begin
          chk("setup_consec", {27'h0, tmr_chipselect, tmr_write_n, tmr_address}, {27'h0, 1'b1, 1'b0, seq_addr[k]});
          step();
        end
        chk("running_after_setup", 32'(running), 32'd1);
        do_stop();
      end
    end

    // three timeouts in periodic mode
    do_start(32'd50000, 1'b1);
    for (int j = 1; j <= 3; j++) begin
      tmr_irq = 1'b1;
      push(3'd0, 16'h0000);
      step();
      tmr_irq = 1'b0;
      chk("irq_tick", 32'(tick), 32'd1);
      chk("irq_count", 32'(tick_count), 32'(j));
      exp_ticks++;
      step();
      chk("irq_back_run", 32'(running), 32'd1);
    end
    step(); step();
    chk("periodic_count", 32'(tick_count), 32'd3);
    chk("periodic_busy", 32'(busy), 32'd1);

    // stop and irq together: stop wins
    tmr_irq = 1'b1; stop = 1'b1;
    push(3'd1, 16'h0008); push(3'd0, 16'h0000);
    step();
    stop = 1'b0;
    chk("wr_stop_not_running", 32'(running), 32'd0);
    step();
    tmr_irq = 1'b0;
    chk("stop_irq_no_tick", 32'(tick), 32'd0);
    chk("stop_irq_count", 32'(tick_count), 32'd3);
    step();
    chk("stop_irq_idle", 32'(busy), 32'd0);
    chk("stop_irq_count_held", 32'(tick_count), 32'd3);

    // one-shot
    do_start(32'd100, 1'b0);
    tmr_irq = 1'b1;
    push(3'd0, 16'h0000);
    step();
    tmr_irq = 1'b0;
    chk("oneshot_tick", 32'(tick), 32'd1);
    chk("oneshot_count", 32'(tick_count), 32'd1);
    exp_ticks++;
    step();
    chk("oneshot_idle", 32'(busy), 32'd0);

    // snapshot
    do_start(32'd1000, 1'b1);
    snap_req = 1'b1;
    push(3'd4, 16'h0000);
    step();
    snap_req = 1'b0;
    n = 1; found = 1'b0;
    while (!found && n < 10) begin
      if (snap_valid === 1'b1) found = 1'b1;
      else begin step(); n++; end
    end
    chk("snap_latency", 32'(n), 32'd4);
    chk("snap_value", snap_value, 32'h0001_1234);
    step();
    chk("snap_valid_single", 32'(snap_valid), 32'd0);
    chk("snap_value_held", snap_value, 32'h0001_1234);
    chk("snap_running", 32'(running), 32'd1);

    // stop arriving mid-snapshot is held until the snapshot completes
    snap_req = 1'b1;
    push(3'd4, 16'h0000); push(3'd1, 16'h0008); push(3'd0, 16'h0000);
    step();
    snap_req = 1'b0;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin step(); n++; end
    chk("latched_stop_idle", 32'(busy), 32'd0);
    chk("latched_stop_writes", 32'(exp_q.size()), 32'd0);

    // reset in the middle of setup
    start = 1'b1; period = 32'd50000; continuous = 1'b1;
    push(3'd2, 16'hC34F); push(3'd3, 16'h0000);
    step();
    start = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    chk("midreset_bus", {tmr_chipselect, tmr_write_n, 11'h0, tmr_address, tmr_writedata}, {1'b0, 1'b1, 30'h0});
    chk("midreset_flags", {27'h0, busy, running, tick, err, snap_valid}, 32'h0);
    chk("midreset_count", 32'(tick_count), 32'h0);
    chk("midreset_snap", snap_value, 32'h0);
    reset_n = 1'b1;
    step(); step();
    chk("post_reset_idle", 32'(busy), 32'd0);

    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    chk("tick_total", 32'(ticks_seen), 32'(exp_ticks));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
